// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: register/data widths and the write-back entry
// carried through the load buffer.
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Which producer owns the register-file write port in a given cycle
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_DROP
  } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending load write-backs with per-entry kill-by-address
// and an address match vector for hazard lookups.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [REG_AW-1:0] kill_addr,
  input  logic [REG_AW-1:0] match_addr,
  output wb_entry_t         head,
  output logic              empty,
  output logic              full,
  output logic [DEPTH-1:0]  match_vec
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]     wr_ptr, rd_ptr, count;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic [DEPTH-1:0]  live;
  logic [REG_AW-1:0] dst_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == PW'(DEPTH));
  assign wr_idx  = wr_ptr[IW-1:0];
  assign rd_idx  = rd_ptr[IW-1:0];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head = '{live: live[rd_idx], dst: dst_mem[rd_idx], data: data_mem[rd_idx]};

  // Live bits are cleared on pop so a set bit always implies an occupied slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      live   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && dst_mem[i] == kill_addr) live[i] <= 1'b0;
      end
      if (do_pop) begin
        live[rd_idx] <= 1'b0;
        rd_ptr       <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        live[wr_idx] <= push_entry.live && !(kill_en && push_entry.dst == kill_addr);
        wr_ptr       <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      dst_mem[wr_idx]  <= push_entry.dst;
      data_mem[wr_idx] <= push_entry.data;
    end
  end

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = live[i] && (dst_mem[i] == match_addr) && !(do_pop && rd_idx == IW'(i));
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port master: merges the ALU result stream with buffered
// load results, filters $0 writes and kills loads superseded by younger ALU writes.
module wb_arbiter
  import mips_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int AW    = REG_AW,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dst,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_dst,
  input  logic [DW-1:0] mem_data,
  input  logic [AW-1:0] q_addr,
  output logic          q_pending,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          RegWrite_en
);

  wb_entry_t        push_entry, head;
  wb_src_t          src;
  logic             fifo_empty, fifo_full, fifo_push, fifo_pop, kill_en;
  logic [DEPTH-1:0] match_vec;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  assign mem_ready  = !fifo_full;
  assign fifo_push  = mem_valid && !fifo_full;
  assign push_entry = '{live: (mem_dst != REG_ZERO), dst: mem_dst, data: mem_data};
  assign kill_en    = alu_valid && (alu_dst != REG_ZERO);
  assign q_pending  = (q_addr != REG_ZERO) && (|match_vec);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .kill_en    (kill_en),
    .kill_addr  (alu_dst),
    .match_addr (q_addr),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .match_vec  (match_vec)
  );

  // ALU always wins, even a $0 write; dead heads are drained without a write
  always_comb begin
    src = SRC_NONE;
    if (alu_valid) begin
      src = SRC_ALU;
    end else if (!fifo_empty) begin
      src = head.live ? SRC_FIFO : SRC_DROP;
    end
  end

  assign fifo_pop = (src == SRC_FIFO) || (src == SRC_DROP);

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = alu_dst;
    sel_data = alu_data;
    case (src)
      SRC_ALU: sel_we = (alu_dst != REG_ZERO);
      SRC_FIFO: begin
        sel_we   = (head.dst != REG_ZERO);
        sel_addr = head.dst;
        sel_data = head.data;
      end
      default: sel_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_en <= 1'b0;
      w_addr      <= '0;
      w_data      <= '0;
    end else begin
      RegWrite_en <= sel_we;
      if (sel_we) begin
        w_addr <= sel_addr;
        w_data <= sel_data;
      end
    end
  end

endmodule
